// File: rtl/demux1to3_stream.sv
// demux1to3_stream: registered 1-to-3 valid/ready demux, one-entry register per channel (clk, rst async high; in_valid/in_ready/in_data/sel in; outK_valid/outK_ready/outK_data out; sel 3 discards); DEMUX_DROP_CNT_EN builds the saturating drop_cnt, else drop_cnt is 0
module demux1to3_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic [7:0]       drop_cnt
);
  logic [2:0]       vld, rdy;
  logic [3:0]       room;
  logic [WIDTH-1:0] dat [3];
  logic             acc;
  assign rdy      = {out2_ready, out1_ready, out0_ready};
  assign room     = {1'b1, ~vld | rdy};
  assign in_ready = room[sel];
  assign acc      = in_valid & in_ready;
  genvar k;
  for (k = 0; k < 3; k++) begin : g_ch
    logic             v;
    logic [WIDTH-1:0] d;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v <= 1'b0;
        d <= '0;
      end else if (acc && sel == 2'(k)) begin
        v <= 1'b1;
        d <= in_data;
      end else if (rdy[k]) begin
        v <= 1'b0;
      end
    assign vld[k] = v;
    assign dat[k] = d;
  end
  assign out0_valid = vld[0];
  assign out1_valid = vld[1];
  assign out2_valid = vld[2];
  assign out0_data  = dat[0];
  assign out1_data  = dat[1];
  assign out2_data  = dat[2];
`ifdef DEMUX_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) drop_cnt <= '0;
    else if (acc && sel == 2'd3 && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_demux1to3_stream.sv
// tb_demux1to3_stream: vector table, hand sequences and random run against a behavioural channel model
module tb_demux1to3_stream;
  logic       clk = 1'b0, rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_data = '0;
  logic [1:0] sel = '0;
  logic [2:0] rdy = 3'b111;
  logic       out0_valid, out1_valid, out2_valid;
  logic [7:0] out0_data, out1_data, out2_data, drop_cnt;
  logic [2:0] vld;
  logic [7:0] dd [3];
  int         npass = 0, ntot = 0;
`ifdef DEMUX_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  always #5 clk = ~clk;
  demux1to3_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sel(sel),
    .out0_valid(out0_valid), .out0_ready(rdy[0]), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(rdy[1]), .out1_data(out1_data),
    .out2_valid(out2_valid), .out2_ready(rdy[2]), .out2_data(out2_data),
    .drop_cnt(drop_cnt)
  );
  assign vld = {out2_valid, out1_valid, out0_valid};
  assign dd[0] = out0_data;
  assign dd[1] = out1_data;
  assign dd[2] = out2_data;
  typedef struct {
    logic       iv;
    logic [1:0] sel;
    logic [7:0] d;
    logic [2:0] r;
    logic       inr;
    logic [2:0] vld;
    logic [7:0] dat;
  } vec_t;
  vec_t tbl [15];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask
  task automatic drive(input logic iv, input logic [1:0] s, input logic [7:0] d, input logic [2:0] r);
    in_valid = iv;
    sel      = s;
    in_data  = d;
    rdy      = r;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic       mv [3];
  logic [7:0] md [3];
  int         cnt;
  logic       e_inr, iv;
  logic [1:0] s;
  logic [7:0] d;
  logic [2:0] r;
  initial begin
    tbl[0]  = '{1'b1, 2'd0, 8'hA5, 3'b111, 1'b1, 3'b001, 8'hA5};
    tbl[1]  = '{1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000, 8'hA5};
    tbl[2]  = '{1'b1, 2'd1, 8'h11, 3'b111, 1'b1, 3'b010, 8'h11};
    tbl[3]  = '{1'b1, 2'd2, 8'h22, 3'b111, 1'b1, 3'b100, 8'h22};
    tbl[4]  = '{1'b1, 2'd0, 8'h33, 3'b111, 1'b1, 3'b001, 8'h33};
    tbl[5]  = '{1'b1, 2'd1, 8'h44, 3'b101, 1'b1, 3'b010, 8'h44};
    tbl[6]  = '{1'b1, 2'd1, 8'h55, 3'b101, 1'b0, 3'b010, 8'h44};
    tbl[7]  = '{1'b1, 2'd2, 8'h66, 3'b101, 1'b1, 3'b110, 8'h66};
    tbl[8]  = '{1'b1, 2'd1, 8'h55, 3'b111, 1'b1, 3'b010, 8'h55};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000, 8'h33};
    for (int i = 10; i < 15; i++) tbl[i] = '{1'b1, 2'd3, 8'(i * 7), 3'b111, 1'b1, 3'b000, 8'h00};
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_data", {8'h00, out2_data, out1_data, out0_data}, 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].inr));
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(vld), 32'(tbl[i].vld));
      if (tbl[i].sel != 2'd3) chk($sformatf("vec%0d_data", i), 32'(dd[tbl[i].sel]), 32'(tbl[i].dat));
    end
    chk("drop5", 32'(drop_cnt), CNT_EN ? 32'd5 : 32'd0);
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, 2'd3, 8'(i), 3'(i));
      if (!in_ready) chk("drop_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    chk("drop_sat", 32'(drop_cnt), CNT_EN ? 32'd255 : 32'd0);
    chk("drop_no_valid", 32'(vld), 32'd0);
    drive(1'b1, 2'd0, 8'h77, 3'b000);
    tick();
    drive(1'b1, 2'd2, 8'h88, 3'b000);
    tick();
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    chk("stall_full", 32'(vld), 32'b101);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(vld), 32'd0);
    chk("async_data", {8'h00, out2_data, out1_data, out0_data}, 32'd0);
    chk("async_drop", 32'(drop_cnt), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0;
      md[k] = 8'h00;
    end
    cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      iv = ($urandom_range(0, 3) != 0);
      s  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      r  = {($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0)};
      drive(iv, s, d, r);
      e_inr = (s == 2'd3) || !mv[s] || r[s];
      chk("rnd_in_ready", 32'(in_ready), 32'(e_inr));
      for (int k = 0; k < 3; k++) if (mv[k] && r[k]) mv[k] = 1'b0;
      if (iv && e_inr) begin
        if (s == 2'd3) cnt = (cnt < 255) ? cnt + 1 : 255;
        else begin
          mv[s] = 1'b1;
          md[s] = d;
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rnd_valid%0d", k), 32'(vld[k]), 32'(mv[k]));
        chk($sformatf("rnd_data%0d", k), 32'(dd[k]), 32'(md[k]));
      end
      chk("rnd_drop", 32'(drop_cnt), CNT_EN ? 32'(cnt) : 32'd0);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
